// File: rtl/mram_ctrl_pkg.sv
// Shared types, derived constants and helpers for the MRAM burst sequencer.
package mram_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StShiftAddr,
        StShiftData,
        StWrSetup,
        StWrStrobe,
        StRdAccess,
        StRdShift,
        StRecover,
        StDone
    } state_e;

    // Default geometry; instances re-derive these from their own parameters.
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 20;
    localparam int unsigned DEF_BURST_MAX  = 8;
    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_ACCESS_CYC = 1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold the longest phase of any state.
    function automatic int unsigned cnt_width(input int unsigned data_w,
                                              input int unsigned addr_w,
                                              input int unsigned setup_cyc,
                                              input int unsigned access_cyc);
        int unsigned longest;
        longest = max2(max2(addr_w, data_w), max2(8 * (data_w / 8), max2(setup_cyc, access_cyc)));
        return $clog2(longest + 1);
    endfunction

    localparam int unsigned NBYTES = DEF_DATA_W / 8;
    localparam int unsigned LEN_W  = $clog2(DEF_BURST_MAX + 1);
    localparam int unsigned CNT_W  = cnt_width(DEF_DATA_W, DEF_ADDR_W, DEF_SETUP_CYC,
                                               DEF_ACCESS_CYC);

    // Deasserted levels of the active-low MRAM control pins.
    localparam logic PIN_CE_IDLE = 1'b1;
    localparam logic PIN_WE_IDLE = 1'b1;
    localparam logic PIN_OE_IDLE = 1'b1;

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mram_burst_ctrl_if.sv
// Command handshake plus shifter/MRAM control bundle of the burst sequencer.
interface mram_burst_ctrl_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BURST_MAX = 8
);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned LEN_W  = $clog2(BURST_MAX + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [NBYTES-1:0] cmd_be;
    logic [LEN_W-1:0]  cmd_len;

    logic              addr_en;
    logic              data_en;
    logic              addr_inc;
    logic              send_data;
    logic              load;
    logic              data_in_from_MRAM_en;
    logic              chip_en;
    logic              write_en;
    logic              out_en;
    logic [NBYTES-1:0] byte_en_n;
    logic              busy;
    logic              done;

    // Host side: issues commands, observes the sequencer.
    modport master (
        output cmd_valid, cmd_write, cmd_be, cmd_len,
        input  cmd_ready, addr_en, data_en, addr_inc, send_data, load,
               data_in_from_MRAM_en, chip_en, write_en, out_en, byte_en_n, busy, done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_write, cmd_be, cmd_len,
        output cmd_ready, addr_en, data_en, addr_inc, send_data, load,
               data_in_from_MRAM_en, chip_en, write_en, out_en, byte_en_n, busy, done
    );

endinterface

// File: rtl/mram_phase_timer.sv
// Loadable down-counter timing each sequencer phase; zero marks its last cycle.
module mram_phase_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Reload on phase entry, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mram_burst_ctrl.sv
// Command sequencer driving the addr/data STP shifters, PTS shifter and MRAM pins.
module mram_burst_ctrl
    import mram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned ACCESS_CYC = 1
) (
    input logic         clk,
    input logic         rst_n,
    mram_burst_ctrl_if.slave bus
);

    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned LW        = $clog2(BURST_MAX + 1);
    localparam int unsigned CW        = cnt_width(DATA_W, ADDR_W, SETUP_CYC, ACCESS_CYC);
    // Write first beat shifts address and data together in one phase.
    localparam int unsigned SA_WR_DUR = max2(ADDR_W, DATA_W);
    localparam int unsigned SA_RD_DUR = ADDR_W;

    state_e          state_q, state_d;
    logic            wr_q, wr_d;
    logic [NB-1:0]   be_q, be_d;
    logic [LW-1:0]   beats_q, beats_d;

    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic [CW-1:0]   tmr_cnt;
    logic            tmr_zero;

    mram_phase_timer #(
        .CNT_W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        if (len == '0) begin
            return LW'(1);
        end else if (32'(len) > BURST_MAX) begin
            return LW'(BURST_MAX);
        end
        return len;
    endfunction

    // State and latched command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            be_q    <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            beats_q <= beats_d;
        end
    end

    // Next-state logic; the phase timer is loaded on every multi-cycle state entry.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        be_d     = be_q;
        beats_d  = beats_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.cmd_valid) begin
                    wr_d    = bus.cmd_write;
                    be_d    = bus.cmd_be;
                    beats_d = clamp_len(bus.cmd_len);
                    if (bus.cmd_be == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StShiftAddr;
                        tmr_load = 1'b1;
                        tmr_val  = bus.cmd_write ? CW'(SA_WR_DUR - 1) : CW'(SA_RD_DUR - 1);
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StShiftAddr: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (wr_q) begin
                        state_d = StWrSetup;
                        tmr_val = CW'(SETUP_CYC - 1);
                    end else begin
                        state_d = StRdAccess;
                        tmr_val = CW'(ACCESS_CYC - 1);
                    end
                end
            end
            StShiftData: begin
                if (tmr_zero) begin
                    state_d  = StWrSetup;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(SETUP_CYC - 1);
                end
            end
            StWrSetup: begin
                if (tmr_zero) begin
                    state_d  = StWrStrobe;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(ACCESS_CYC - 1);
                end
            end
            StWrStrobe: begin
                if (tmr_zero) begin
                    state_d = StRecover;
                end
            end
            StRdAccess: begin
                if (tmr_zero) begin
                    state_d  = StRdShift;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(8 * popcount(64'(be_q)) - 1);
                end
            end
            StRdShift: begin
                if (tmr_zero) begin
                    state_d = StRecover;
                end
            end
            StRecover: begin
                if (beats_q > LW'(1)) begin
                    beats_d  = beats_q - 1'b1;
                    tmr_load = 1'b1;
                    if (wr_q) begin
                        state_d = StShiftData;
                        tmr_val = CW'(DATA_W - 1);
                    end else begin
                        state_d = StRdAccess;
                        tmr_val = CW'(ACCESS_CYC - 1);
                    end
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Decoded outputs; pins sit at idle levels unless the state drives them.
    always_comb begin
        int unsigned sa_dur;
        sa_dur                   = wr_q ? SA_WR_DUR : SA_RD_DUR;
        bus.cmd_ready            = 1'b0;
        bus.addr_en              = 1'b0;
        bus.data_en              = 1'b0;
        bus.addr_inc             = 1'b0;
        bus.send_data            = 1'b0;
        bus.load                 = 1'b0;
        bus.data_in_from_MRAM_en = 1'b0;
        bus.chip_en              = PIN_CE_IDLE;
        bus.write_en             = PIN_WE_IDLE;
        bus.out_en               = PIN_OE_IDLE;
        bus.byte_en_n            = '1;
        bus.busy                 = 1'b1;
        bus.done                 = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            StShiftAddr: begin
                // Timer counts down, so the leading cycles carry the highest counts.
                bus.addr_en = (32'(tmr_cnt) >= sa_dur - ADDR_W);
                bus.data_en = wr_q && (32'(tmr_cnt) >= sa_dur - DATA_W);
            end
            StShiftData: begin
                bus.data_en = 1'b1;
            end
            StWrSetup: begin
                bus.write_en  = 1'b0;
                bus.byte_en_n = ~be_q;
            end
            StWrStrobe: begin
                bus.chip_en   = 1'b0;
                bus.write_en  = 1'b0;
                bus.send_data = 1'b1;
                bus.byte_en_n = ~be_q;
            end
            StRdAccess: begin
                bus.chip_en   = 1'b0;
                bus.out_en    = 1'b0;
                bus.send_data = 1'b1;
                bus.byte_en_n = ~be_q;
                bus.load      = tmr_zero;
            end
            StRdShift: begin
                bus.data_in_from_MRAM_en = 1'b1;
                bus.send_data            = 1'b1;
            end
            StRecover: begin
                bus.addr_inc = (beats_q > LW'(1));
            end
            StDone: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                bus.done      = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mram_burst_ctrl.sv
// Directed bench for mram_burst_ctrl at default geometry (16-bit data, 20-bit address).
module tb_mram_burst_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mram_burst_ctrl_if #(.DATA_W(16), .BURST_MAX(8)) bus ();

    mram_burst_ctrl #(
        .DATA_W     (16),
        .ADDR_W     (20),
        .BURST_MAX  (8),
        .SETUP_CYC  (1),
        .ACCESS_CYC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Per-cycle trace, index = cycles after the acceptance edge; active-low pins stored asserted-high.
    logic [199:0] l_addr, l_data, l_inc, l_ce, l_we, l_oe, l_load, l_pts, l_done, l_busy, l_ready;
    logic [1:0]   l_ben [0:199];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int first_of(input logic [199:0] v);
        for (int i = 0; i < 200; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last_of(input logic [199:0] v);
        for (int i = 199; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int count_of(input logic [199:0] v);
        int n = 0;
        for (int i = 0; i < 200; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic issue(input logic wr, input logic [1:0] be, input logic [3:0] len);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_be    = be;
        bus.cmd_len   = len;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run(input int n);
        l_addr = '0; l_data = '0; l_inc = '0; l_ce = '0; l_we = '0; l_oe = '0;
        l_load = '0; l_pts = '0; l_done = '0; l_busy = '0; l_ready = '0;
        for (int k = 0; k < 200; k++) l_ben[k] = 2'b11;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            l_addr[k]  = bus.addr_en;
            l_data[k]  = bus.data_en;
            l_inc[k]   = bus.addr_inc;
            l_ce[k]    = ~bus.chip_en;
            l_we[k]    = ~bus.write_en;
            l_oe[k]    = ~bus.out_en;
            l_load[k]  = bus.load;
            l_pts[k]   = bus.data_in_from_MRAM_en;
            l_done[k]  = bus.done;
            l_busy[k]  = bus.busy;
            l_ready[k] = bus.cmd_ready;
            l_ben[k]   = bus.byte_en_n;
        end
    endtask

    task automatic check_single_write(input string p);
        check({p, "_addr_first"}, first_of(l_addr), 1);
        check({p, "_addr_last"},  last_of(l_addr), 20);
        check({p, "_data_first"}, first_of(l_data), 1);
        check({p, "_data_last"},  last_of(l_data), 16);
        check({p, "_we_first"},   first_of(l_we), 21);
        check({p, "_we_last"},    last_of(l_we), 22);
        check({p, "_ce_first"},   first_of(l_ce), 22);
        check({p, "_ce_count"},   count_of(l_ce), 1);
        check({p, "_done_first"}, first_of(l_done), 24);
        check({p, "_done_count"}, count_of(l_done), 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_be    = 2'b00;
        bus.cmd_len   = 4'd0;

        // Reset values.
        #12;
        check("rst_ready", int'(bus.cmd_ready), 1);
        check("rst_ce",    int'(bus.chip_en), 1);
        check("rst_we",    int'(bus.write_en), 1);
        check("rst_oe",    int'(bus.out_en), 1);
        check("rst_ben",   int'(bus.byte_en_n), 3);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single full-word write.
        issue(1'b1, 2'b11, 4'd1);
        run(26);
        check_single_write("w1");
        check("w1_ben_strobe", int'(l_ben[22]), 0);
        check("w1_busy_1",     int'(l_busy[1]), 1);
        check("w1_ready_10",   int'(l_ready[10]), 0);
        check("w1_ready_done", int'(l_ready[24]), 1);
        check("w1_oe_count",   count_of(l_oe), 0);
        check("w1_inc_count",  count_of(l_inc), 0);

        // Full-word read.
        issue(1'b0, 2'b11, 4'd1);
        run(41);
        check("rd_ce_first",  first_of(l_ce), 21);
        check("rd_ce_count",  count_of(l_ce), 1);
        check("rd_oe_first",  first_of(l_oe), 21);
        check("rd_oe_count",  count_of(l_oe), 1);
        check("rd_we_count",  count_of(l_we), 0);
        check("rd_load_at",   first_of(l_load), 21);
        check("rd_load_cnt",  count_of(l_load), 1);
        check("rd_pts_first", first_of(l_pts), 22);
        check("rd_pts_last",  last_of(l_pts), 37);
        check("rd_pts_count", count_of(l_pts), 16);
        check("rd_data_cnt",  count_of(l_data), 0);
        check("rd_done",      first_of(l_done), 39);

        // Low-byte read.
        issue(1'b0, 2'b01, 4'd1);
        run(33);
        check("hr_ben_access", int'(l_ben[21]), 2);
        check("hr_pts_first",  first_of(l_pts), 22);
        check("hr_pts_last",   last_of(l_pts), 29);
        check("hr_pts_count",  count_of(l_pts), 8);
        check("hr_done",       first_of(l_done), 31);

        // Three-beat write burst.
        issue(1'b1, 2'b11, 4'd3);
        run(64);
        check("bw_addr_count", count_of(l_addr), 20);
        check("bw_data_count", count_of(l_data), 48);
        check("bw_inc_first",  first_of(l_inc), 23);
        check("bw_inc_last",   last_of(l_inc), 42);
        check("bw_inc_count",  count_of(l_inc), 2);
        check("bw_ce_first",   first_of(l_ce), 22);
        check("bw_ce_41",      int'(l_ce[41]), 1);
        check("bw_ce_last",    last_of(l_ce), 60);
        check("bw_ce_count",   count_of(l_ce), 3);
        check("bw_we_count",   count_of(l_we), 6);
        check("bw_done",       first_of(l_done), 62);
        check("bw_pin_clash",  count_of(l_ce & l_we & l_oe), 0);

        // Empty byte select: nop.
        issue(1'b1, 2'b00, 4'd0);
        run(4);
        check("nop_done",       first_of(l_done), 1);
        check("nop_done_count", count_of(l_done), 1);
        check("nop_ce_count",   count_of(l_ce), 0);
        check("nop_busy_count", count_of(l_busy), 0);

        // Over-long burst clamps to eight beats.
        issue(1'b1, 2'b11, 4'd15);
        run(160);
        check("cl_ce_count",  count_of(l_ce), 8);
        check("cl_inc_count", count_of(l_inc), 7);
        check("cl_done",      first_of(l_done), 157);

        // Reset in the middle of a read's shift-out.
        issue(1'b0, 2'b11, 4'd1);
        run(29);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr_ready", int'(bus.cmd_ready), 1);
        check("mr_ce",    int'(bus.chip_en), 1);
        check("mr_oe",    int'(bus.out_en), 1);
        check("mr_pts",   int'(bus.data_in_from_MRAM_en), 0);
        check("mr_busy",  int'(bus.busy), 0);
        check("mr_send",  int'(bus.send_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 2'b11, 4'd1);
        run(26);
        check_single_write("w2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
